// File: rtl/mult_defs.sv
// Shared definitions for the shift-and-add multiplier: state encodings,
// default operand width and the shift-counter width helper.
package mult_defs;

    localparam int N_DEFAULT = 16;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_EVAL  = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int CNT_W_DEFAULT = $clog2(N_DEFAULT);

    // A one-bit operand still needs a one-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_bit_counter.sv
// Shift counter for the multiplier sequencer: cleared in LOAD, stepped on
// every shift, flags the last shift (count == N-1).
module mult_bit_counter
    import mult_defs::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic Clk,
    input  logic Rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam int CW = cnt_width(N);

    logic [CW-1:0] cnt;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tc = (cnt == CW'(N - 1));

endmodule

// File: rtl/mult_control.sv
// Sequencing FSM for the shift-and-add multiplier. Drives Load/Ad/Sh into the
// accumulator, chooses add or shift from the accumulator LSB, raises Done.
module mult_control
    import mult_defs::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       St,
    input  logic       M,
    output logic       Load,
    output logic       Ad,
    output logic       Sh,
    output logic       Done,
    output logic       Busy,
    output logic [2:0] state_dbg
);

    // Start protocol: St is a level. A multiply begins on the first edge that
    // sees St=1 in IDLE; the result is held with Done=1 until an edge sees
    // St=0, so a start held high never retriggers.

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       last_shift;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (St) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_EVAL;
            S_EVAL: begin
                if (M) begin
                    state_nxt = S_SHIFT;
                end else if (last_shift) begin
                    state_nxt = S_DONE;
                end
            end
            S_SHIFT: state_nxt = last_shift ? S_DONE : S_EVAL;
            S_DONE:  if (!St) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // EVAL is Mealy on M: add when the bit is 1, otherwise shift straight away.
    assign Load      = (state == S_LOAD);
    assign Ad        = (state == S_EVAL) && M;
    assign Sh        = ((state == S_EVAL) && !M) || (state == S_SHIFT);
    assign Done      = (state == S_DONE);
    assign Busy      = (state == S_LOAD) || (state == S_EVAL) || (state == S_SHIFT);
    assign state_dbg = state;

    mult_bit_counter #(.N(N)) u_cnt (
        .Clk (Clk),
        .Rst (Rst),
        .clr (Load),
        .inc (Sh),
        .tc  (last_shift)
    );

    a_ctrl_onehot: assert property (@(posedge Clk) disable iff (Rst)
        $onehot0({Load, Ad, Sh}));

    a_done_busy: assert property (@(posedge Clk) disable iff (Rst)
        !(Done && Busy));

endmodule

// File: tb/tb_mult_control.sv
// Bench for mult_control with a behavioural 33-bit accumulator closing the M loop.
module tb_mult_control;
    import mult_defs::*;

    localparam int N = 16;

    logic         clk;
    logic         rst;
    logic         st;
    logic         m;
    logic         load, ad, sh, done, busy;
    logic [2:0]   state_dbg;

    logic [2*N:0] acc;
    logic [N-1:0] mcand_r, mplier_r;

    int checks;
    int failures;

    mult_control #(.N(N)) dut (
        .Clk       (clk),
        .Rst       (rst),
        .St        (st),
        .M         (m),
        .Load      (load),
        .Ad        (ad),
        .Sh        (sh),
        .Done      (done),
        .Busy      (busy),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference accumulator: load multiplier low, add multiplicand high, shift right.
    initial acc = '0;
    always @(posedge clk) begin
        if (load) begin
            acc <= {{(N+1){1'b0}}, mplier_r};
        end else if (ad) begin
            acc[2*N:N] <= acc[2*N:N] + {1'b0, mcand_r};
        end else if (sh) begin
            acc <= acc >> 1;
        end
    end
    assign m = acc[0];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_state"}, 64'(state_dbg), 64'(S_IDLE));
        check({name, "_outs"}, 64'({load, ad, sh, done, busy}), 64'(0));
    endtask

    // Waits (bounded) for Done at a negedge; cyc counts negedges waited.
    task automatic wait_done(input string name, output int cyc);
        cyc = 0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            failures++;
            checks++;
            $display("FAIL %s_timeout: got done=0 expected done=1 within 60 cycles", name);
        end
    endtask

    typedef struct {
        logic [N-1:0]   mc;
        logic [N-1:0]   mp;
        logic [2*N-1:0] prod;
        int             n_ad;
        int             done_cyc;
        bit             tog;
    } vec_t;

    // Cycle 0 is the edge sampling St; Load is cycle 1; Done at 2+N+popcount.
    task automatic run_vec(input string name, input vec_t v);
        int n_load, n_ad, n_sh, cyc;
        bit seen;
        n_load = 0; n_ad = 0; n_sh = 0; seen = 0;
        @(negedge clk);
        mcand_r = v.mc;
        mplier_r = v.mp;
        st = 1'b1;
        @(negedge clk);
        if (!v.tog) st = 1'b0;
        for (cyc = 1; cyc <= 40; cyc++) begin
            if (done) begin
                seen = 1;
                break;
            end
            n_load += int'(load);
            n_ad   += int'(ad);
            n_sh   += int'(sh);
            check({name, "_onehot"}, 64'($onehot0({load, ad, sh})), 64'(1));
            check({name, "_busy"}, 64'(busy), 64'(1));
            if (v.tog) st = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        check({name, "_done_seen"}, 64'(seen), 64'(1));
        check({name, "_done_cyc"}, 64'(cyc), 64'(v.done_cyc));
        check({name, "_done_busy"}, 64'({done, busy}), 64'(2'b10));
        check({name, "_n_load"}, 64'(n_load), 64'(1));
        check({name, "_n_ad"}, 64'(n_ad), 64'(v.n_ad));
        check({name, "_n_sh"}, 64'(n_sh), 64'(N));
        check({name, "_product"}, 64'(acc[2*N-1:0]), 64'(v.prod));
        st = 1'b0;
        @(negedge clk);
        check_idle({name, "_back_idle"});
    endtask

    vec_t vecs[6];

    initial begin
        int cyc;
        int shs;
        checks = 0;
        failures = 0;
        st = 1'b0;
        mcand_r = '0;
        mplier_r = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("reset_held");
        rst = 1'b0;
        @(negedge clk);
        check_idle("reset_released");

        vecs[0] = '{16'h000B, 16'h000D, 32'h0000_008F, 3, 21, 1'b0};
        vecs[1] = '{16'h1234, 16'h0000, 32'h0000_0000, 0, 18, 1'b0};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 16, 34, 1'b0};
        vecs[3] = '{16'h0001, 16'h8000, 32'h0000_8000, 1, 19, 1'b0};
        vecs[4] = '{16'hABCD, 16'h0001, 32'h0000_ABCD, 1, 19, 1'b0};
        vecs[5] = '{16'h00C8, 16'h0A5A, 32'h0008_1650, 6, 24, 1'b1};

        for (int i = 0; i < 6; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // St held through DONE: no restart until St drops and rises again.
        @(negedge clk);
        mcand_r = 16'h0002;
        mplier_r = 16'h0003;
        st = 1'b1;
        wait_done("hold", cyc);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("hold_done", 64'(done), 64'(1));
            check("hold_no_load", 64'(load), 64'(0));
        end
        st = 1'b0;
        @(negedge clk);
        check_idle("hold_release");
        st = 1'b1;
        @(negedge clk);
        check("hold_restart_load", 64'(load), 64'(1));
        st = 1'b0;
        wait_done("restart", cyc);
        check("restart_product", 64'(acc[2*N-1:0]), 64'(6));
        @(negedge clk);
        check_idle("restart_idle");

        // Asynchronous reset just after the 7th shift.
        mcand_r = 16'h0007;
        mplier_r = 16'h00FF;
        st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        shs = 0;
        cyc = 0;
        while (shs < 7 && cyc < 60) begin
            shs += int'(sh);
            cyc++;
            if (shs < 7) @(negedge clk);
        end
        check("rst_mid_reached", 64'(shs), 64'(7));
        check("rst_mid_busy", 64'(busy), 64'(1));
        #1 rst = 1'b1;
        #1;
        check_idle("rst_async");
        #2 rst = 1'b0;
        @(negedge clk);
        check_idle("rst_after");
        run_vec("post_rst", '{16'h0003, 16'h0005, 32'h0000_000F, 2, 20, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
